// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the union-find decoder PE array.
// Optional ERASURE_LOADING stage enabled by defining HELIOS_ERASURE_EN.
module decoder_stage_controller #(
  parameter int PU_COUNT      = 64,
  parameter int MAX_ITER      = 31,
  parameter int SETTLE_CYCLES = 3,
  parameter int ITER_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  measurement_valid,
  output logic                  measurement_ready,
  input  logic                  erasure_present,
  input  logic [PU_COUNT-1:0]   busy,
  input  logic [PU_COUNT-1:0]   odd,
  output logic [2:0]            global_stage,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ITER_WIDTH-1:0] iteration_count,
  output logic                  timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GROW  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_PEEL  = 3'd3;
  localparam logic [2:0] S_PREP  = 3'd4;
  localparam logic [2:0] S_LOAD  = 3'd5;
  localparam logic [2:0] S_RES   = 3'd6;
  localparam logic [2:0] S_ERASE = 3'd7;

  localparam int CW =
    (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [ITER_WIDTH-1:0] ITER_MAX =
    ITER_WIDTH'(MAX_ITER);
  localparam logic [ITER_WIDTH-1:0] ITER_ONE =
    ITER_WIDTH'(1);

  logic [2:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [ITER_WIDTH-1:0] r_iter;
  logic                  r_timeout;
  logic                  r_ready;
  logic                  r_result_valid;

  logic [2:0]            w_next;
  logic [CW-1:0]         w_cnt_next;
  logic [ITER_WIDTH-1:0] w_iter_next;
  logic                  w_timeout_next;
  logic                  w_accept;
  logic                  w_busy_any;
  logic                  w_odd_any;

`ifdef HELIOS_ERASURE_EN
  logic r_erasure;
  logic w_erasure_next;
`else
  logic w_unused_erasure;
  assign w_unused_erasure = erasure_present;
`endif

  assign w_accept   = measurement_valid && r_ready;
  assign w_busy_any = |busy;
  assign w_odd_any  = |odd;

  // r_cnt doubles as settle counter and 2-cycle hold for LOAD/GROW
  always_comb begin
    w_next         = r_state;
    w_cnt_next     = r_cnt;
    w_iter_next    = r_iter;
    w_timeout_next = r_timeout;
`ifdef HELIOS_ERASURE_EN
    w_erasure_next = r_erasure;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next         = S_PREP;
          w_iter_next    = '0;
          w_timeout_next = 1'b0;
`ifdef HELIOS_ERASURE_EN
          w_erasure_next = erasure_present;
`endif
        end
      end
      S_PREP: begin
        w_next     = S_LOAD;
        w_cnt_next = CNT_ONE;
      end
      S_LOAD: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else begin
`ifdef HELIOS_ERASURE_EN
          if (r_erasure) begin
            w_next = S_ERASE;
          end else begin
            w_next     = S_MERGE;
            w_cnt_next = SETTLE_LD;
          end
`else
          w_next     = S_MERGE;
          w_cnt_next = SETTLE_LD;
`endif
        end
      end
      S_ERASE: begin
        w_next     = S_MERGE;
        w_cnt_next = SETTLE_LD;
      end
      S_MERGE: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else if (!w_busy_any) begin
          if (w_odd_any && (r_iter < ITER_MAX)) begin
            w_next     = S_GROW;
            w_cnt_next = CNT_ONE;
          end else begin
            w_next         = S_PEEL;
            w_cnt_next     = SETTLE_LD;
            w_timeout_next = w_odd_any;
          end
        end
      end
      S_GROW: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else begin
          w_next     = S_MERGE;
          w_cnt_next = SETTLE_LD;
          if (r_iter < ITER_MAX) begin
            w_iter_next = r_iter + ITER_ONE;
          end
        end
      end
      S_PEEL: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else if (!w_busy_any) begin
          w_next = S_RES;
        end
      end
      S_RES: begin
        if (result_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_iter         <= '0;
      r_timeout      <= 1'b0;
      r_ready        <= 1'b0;
      r_result_valid <= 1'b0;
`ifdef HELIOS_ERASURE_EN
      r_erasure      <= 1'b0;
`endif
    end else begin
      r_state        <= w_next;
      r_cnt          <= w_cnt_next;
      r_iter         <= w_iter_next;
      r_timeout      <= w_timeout_next;
      r_ready        <= (r_state == S_IDLE) && !w_accept;
      r_result_valid <= (w_next == S_RES);
`ifdef HELIOS_ERASURE_EN
      r_erasure      <= w_erasure_next;
`endif
    end
  end

  assign global_stage      = r_state;
  assign measurement_ready = r_ready;
  assign result_valid      = r_result_valid;
  assign iteration_count   = r_iter;
  assign timeout           = r_timeout;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Bench for decoder_stage_controller: table rows, random rounds,
// mid-round reset, all checked against a per-round stage schedule.
module tb_decoder_stage_controller;

  localparam int PU     = 8;
  localparam int MAXI   = 3;
  localparam int SETTLE = 3;
  localparam int IW     = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GROW  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_PEEL  = 3'd3;
  localparam logic [2:0] ST_PREP  = 3'd4;
  localparam logic [2:0] ST_LOAD  = 3'd5;
  localparam logic [2:0] ST_RES   = 3'd6;
  localparam logic [2:0] ST_ERASE = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          measurement_valid;
  logic          measurement_ready;
  logic          erasure_present;
  logic [PU-1:0] busy;
  logic [PU-1:0] odd;
  logic [2:0]    global_stage;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] iteration_count;
  logic          timeout;

  decoder_stage_controller #(
    .PU_COUNT(PU), .MAX_ITER(MAXI),
    .SETTLE_CYCLES(SETTLE), .ITER_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .measurement_valid(measurement_valid),
    .measurement_ready(measurement_ready),
    .erasure_present(erasure_present),
    .busy(busy), .odd(odd),
    .global_stage(global_stage),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .iteration_count(iteration_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_odd;
    int ext_m;
    int ext_p;
    bit sba;
    bit er;
    int hold;
    int exp_it;
    bit exp_to;
  } vec_t;

  vec_t tbl[6];

  int checks = 0;
  int errors = 0;
  int prev_it = 0;
  bit prev_to = 1'b0;

  logic [2:0]    q_stage[$];
  logic [PU-1:0] q_busy[$];
  logic [PU-1:0] q_odd[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [PU-1:0] rnd();
    return PU'($urandom);
  endfunction

  function automatic logic [PU-1:0] hi();
    logic [PU-1:0] v;
    v = rnd();
    v[$urandom_range(PU-1)] = 1'b1;
    return v;
  endfunction

  task automatic push(input logic [2:0] s,
                      input logic [PU-1:0] b,
                      input logic [PU-1:0] o);
    q_stage.push_back(s);
    q_busy.push_back(b);
    q_odd.push_back(o);
  endtask

  // settle cycles, then `extra` busy cycles, then one exit cycle
  task automatic push_visit(input logic [2:0] s, input int extra,
                            input logic [PU-1:0] o_exit,
                            input bit sba);
    for (int k = 0; k < SETTLE; k++)
      push(s, sba ? hi() : rnd(), rnd());
    for (int k = 0; k < extra; k++)
      push(s, hi(), rnd());
    push(s, '0, o_exit);
  endtask

  task automatic build(input int n_odd, input int ext_m,
                       input int ext_p, input bit sba,
                       input bit er);
    int it;
    q_stage.delete();
    q_busy.delete();
    q_odd.delete();
    push(ST_PREP, rnd(), rnd());
    push(ST_LOAD, rnd(), rnd());
    push(ST_LOAD, rnd(), rnd());
`ifdef HELIOS_ERASURE_EN
    if (er) push(ST_ERASE, rnd(), rnd());
`else
    if (er) it = 0;
`endif
    it = 0;
    for (int v = 0; ; v++) begin
      push_visit(ST_MERGE, ext_m,
                 (v < n_odd) ? hi() : '0, sba);
      if (v < n_odd && it < MAXI) begin
        push(ST_GROW, rnd(), rnd());
        push(ST_GROW, rnd(), rnd());
        it++;
      end else begin
        break;
      end
    end
    push_visit(ST_PEEL, ext_p, rnd(), sba);
  endtask

  task automatic run_round(input vec_t v);
    int w;
    build(v.n_odd, v.ext_m, v.ext_p, v.sba, v.er);
    w = 0;
    while (!measurement_ready && w < 4) begin
      @(negedge clk);
      w++;
    end
    chk("idle_ready", measurement_ready, 1);
    chk("idle_stage", global_stage, ST_IDLE);
    chk("idle_hold_iter", iteration_count, prev_it);
    chk("idle_hold_timeout", timeout, prev_to);
    measurement_valid = 1'b1;
    erasure_present   = v.er;
    busy = rnd();
    odd  = rnd();
    for (int i = 0; i < q_stage.size(); i++) begin
      @(negedge clk);
      chk($sformatf("stage[%0d]", i), global_stage, q_stage[i]);
      chk("rv_low", result_valid, 0);
      chk("ready_low", measurement_ready, 0);
      if (i == 0) begin
        chk("accept_iter_clr", iteration_count, 0);
        chk("accept_to_clr", timeout, 0);
      end
      busy = q_busy[i];
      odd  = q_odd[i];
      measurement_valid = 1'($urandom);
      erasure_present   = 1'($urandom);
      result_ready      = 1'($urandom);
    end
    for (int h = 0; h <= v.hold; h++) begin
      @(negedge clk);
      chk("res_stage", global_stage, ST_RES);
      chk("res_valid", result_valid, 1);
      chk("res_iter", iteration_count, v.exp_it);
      chk("res_timeout", timeout, v.exp_to);
      chk("res_ready_low", measurement_ready, 0);
      result_ready      = (h == v.hold);
      measurement_valid = 1'b0;
      busy = rnd();
      odd  = rnd();
    end
    @(negedge clk);
    chk("post_stage", global_stage, ST_IDLE);
    chk("post_rv", result_valid, 0);
    chk("post_ready", measurement_ready, 0);
    result_ready = 1'($urandom);
    prev_it = v.exp_it;
    prev_to = v.exp_to;
  endtask

  initial begin
    vec_t r;
    bit found;
    tbl[0] = '{0, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{2, 0, 0, 1'b0, 1'b0, 1, 2, 1'b0};
    tbl[2] = '{0, 7, 0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[3] = '{0, 0, 0, 1'b1, 1'b0, 2, 0, 1'b0};
    tbl[4] = '{5, 0, 2, 1'b0, 1'b0, 0, 3, 1'b1};
    tbl[5] = '{1, 0, 0, 1'b0, 1'b1, 5, 1, 1'b0};

    reset = 1'b1;
    measurement_valid = 1'b0;
    erasure_present   = 1'b0;
    busy = '0;
    odd  = '0;
    result_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stage", global_stage, ST_IDLE);
    chk("rst_ready", measurement_ready, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_iter", iteration_count, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_rise", measurement_ready, 1);

    for (int t = 0; t < 6; t++) run_round(tbl[t]);

    for (int n = 0; n < 20; n++) begin
      r.n_odd  = $urandom_range(0, 5);
      r.ext_m  = $urandom_range(0, 4);
      r.ext_p  = $urandom_range(0, 4);
      r.sba    = 1'($urandom);
      r.er     = 1'($urandom);
      r.hold   = $urandom_range(0, 3);
      r.exp_it = (r.n_odd < MAXI) ? r.n_odd : MAXI;
      r.exp_to = (r.n_odd > MAXI);
      run_round(r);
    end

    // abort a round with reset during the third GROW visit
    while (!measurement_ready) @(negedge clk);
    measurement_valid = 1'b1;
    busy = '0;
    odd  = '1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      measurement_valid = 1'b0;
      if (global_stage == ST_GROW && iteration_count == 2)
        found = 1'b1;
    end
    chk("abort_reach_grow2", found, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_stage", global_stage, ST_IDLE);
    chk("abort_iter", iteration_count, 0);
    chk("abort_timeout", timeout, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_ready", measurement_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_rise", measurement_ready, 1);
    chk("abort_idle", global_stage, ST_IDLE);
    prev_it = 0;
    prev_to = 1'b0;

    run_round(tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_stage_controller.md
Name: decoder_stage_controller

Overview:
- Global stage sequencer for the single-FPGA union-find decoder array.
- Drives the global_stage bus into every processing unit and consumes their busy and odd flags.
- Decides when to grow, merge and peel, and when a decoding round is done.
- Sits between the measurement-ingest front end and the PE array, with a valid/ready handshake on each side.

Parameters:
- PU_COUNT, 64, number of processing units whose busy/odd flags are observed.
- MAX_ITER, 31, maximum grow iterations before a round is aborted.
- SETTLE_CYCLES, 3, cycles busy is ignored after entering MERGE or PEELING (covers PE stage register plus busy register latency).
- ITER_WIDTH, 5, width of the iteration counter; must hold MAX_ITER.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- measurement_valid  in  1  front end has a full syndrome round on the measurement bus.
- measurement_ready  out  1  controller accepts a new round.
- erasure_present  in  1  round carries erasure data; sampled with measurement_valid.
- busy  in  PU_COUNT  per-PE busy flags.
- odd  in  PU_COUNT  per-PE odd-cluster flags.
- global_stage  out  STAGE_WIDTH(3)  stage broadcast to all PEs.
- result_valid  out  1  peeling finished; neighbor_is_error outputs are final.
- result_ready  in  1  downstream has consumed the correction.
- iteration_count  out  ITER_WIDTH  grow iterations used in the current or last round.
- timeout  out  1  last round hit MAX_ITER without converging.

Behaviour:
- Stage encodings come from the shared parameter file: IDLE=0, GROW=1, MERGE=2, PEELING=3, MEASUREMENT_PREPARING=4, MEASUREMENT_LOADING=5, RESULT_VALID=6, ERASURE_LOADING=7.
- global_stage is a registered FSM state output, with no combinational path from inputs.
- Reset values: global_stage=IDLE, measurement_ready=0, result_valid=0, iteration_count=0, timeout=0, settle counter=0.
- IDLE:
  - measurement_ready=1 (registered; goes high the cycle after entering IDLE).
  - On measurement_valid && measurement_ready: go to MEASUREMENT_PREPARING, clear iteration_count and timeout, latch erasure_present.
- MEASUREMENT_PREPARING: held exactly 1 cycle, then MEASUREMENT_LOADING.
- MEASUREMENT_LOADING:
  - Held exactly 2 cycles, because PEs sample on their delayed stage copy with last_stage==PREPARING.
  - Then go to ERASURE_LOADING (feature only) or MERGE.
- MERGE:
  - Load the settle counter with SETTLE_CYCLES on entry.
  - While the counter is nonzero, decrement and ignore busy.
  - Once it reaches zero, exit on the first cycle with ~|busy:
    - |odd and iteration_count<MAX_ITER -> GROW.
    - |odd and iteration_count==MAX_ITER -> PEELING and set timeout=1.
    - ~|odd -> PEELING.
- GROW:
  - Held exactly 2 cycles, so the PE increase pulse fires once per entry.
  - On exit, iteration_count += 1 (saturating at MAX_ITER), then MERGE.
- PEELING:
  - Settle as in MERGE, then exit to RESULT_VALID on the first ~|busy cycle.
- RESULT_VALID:
  - result_valid=1, global_stage=RESULT_VALID.
  - Hold until result_ready is sampled high, then go to IDLE.
  - result_valid drops in the same edge as the transition.
- measurement_valid outside IDLE is ignored (measurement_ready=0). The front end must hold valid until accepted.
- busy/odd are sampled only in MERGE/PEELING after settling. Values in other stages are don't-care.
- reset mid-round: next cycle global_stage=IDLE and all counters cleared. No result_valid is produced for the aborted round.
- result_ready high while not in RESULT_VALID has no effect.
- iteration_count and timeout hold their values through IDLE until the next accepted round.

Optional Feature:
- Macro HELIOS_ERASURE_EN.
- Defined: if the latched erasure_present=1, insert exactly 1 cycle of ERASURE_LOADING between MEASUREMENT_LOADING and MERGE. PEs reset root/parent on this stage.
- Not defined: erasure_present port is present but ignored. The FSM never emits ERASURE_LOADING; LOADING always goes directly to MERGE.

Test Plan:
- Reset, then measurement_valid=1, busy=0, odd=0 -> stages PREPARING(1 cycle), LOADING(2), MERGE(4: 3 settle plus 1 exit cycle), PEELING(4), RESULT_VALID. Then iteration_count=0, timeout=0, and result_valid=1 until result_ready=1.
- odd=1 through the first two MERGE exits, then odd=0 -> exactly 2 GROW visits of 2 cycles each, iteration_count=2 in RESULT_VALID.
- busy=1 for 10 cycles after MERGE entry -> MERGE lasts 11 cycles (10 busy cycles plus 1 exit cycle). Likewise, busy asserted only during settle cycles does not extend MERGE beyond 4 cycles.
- odd held at 1 with MAX_ITER=3 -> 3 GROW visits, then PEELING; timeout=1, iteration_count=3.
- With HELIOS_ERASURE_EN: erasure_present=1 -> a single ERASURE_LOADING cycle between LOADING and MERGE. With erasure_present=0, or with the macro off, none is emitted.
- reset asserted during GROW at iteration 2 -> next cycle IDLE, iteration_count=0, result_valid=0, measurement_ready=1 one cycle later. result_ready held low in RESULT_VALID for 5 cycles -> state and result_valid held for all 5.
